// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - serial line, frame configuration and received-word signals of the UART receiver
interface uart_rx_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  parity_EN;
  logic                  parity_type;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic                  busy;

  modport master (
    output rx_in, prescale, parity_EN, parity_type,
    input  p_data, data_valid, parity_error, stop_error, busy
  );

  modport slave (
    input  rx_in, prescale, parity_EN, parity_type,
    output p_data, data_valid, parity_error, stop_error, busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - oversampling UART frame receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_fsm_if.slave bus
);
  localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  sample_q, sample_d;
  logic                  par_err_q, par_err_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;

  logic [5:0] mid;
  logic       last_edge;
  logic       sample_vld;
  logic       sample_now;

  assign mid       = {1'b0, prescale_q[5:1]};
  assign last_edge = (edge_cnt_q == prescale_q - 6'd1);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  // The bit value resolves one clock after mid, voting the two stored samples with the live line.
  assign sample_vld = (edge_cnt_q == mid + 6'd1);
  assign sample_now = (maj_q[0] & maj_q[1]) | (maj_q[0] & bus.rx_in) | (maj_q[1] & bus.rx_in);

  // Capture the line at mid-1 and mid for the later vote.
  always_comb begin
    maj_d = maj_q;
    if (edge_cnt_q == mid - 6'd1) maj_d[0] = bus.rx_in;
    if (edge_cnt_q == mid)        maj_d[1] = bus.rx_in;
  end

  // Vote sample registers.
  always_ff @(posedge clk) begin
    if (rst) maj_q <= '0;
    else     maj_q <= maj_d;
  end
`else
  assign sample_vld = (edge_cnt_q == mid);
  assign sample_now = bus.rx_in;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      prescale_q     <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      sample_q       <= 1'b0;
      par_err_q      <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      prescale_q     <= prescale_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      sample_q       <= sample_d;
      par_err_q      <= par_err_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  // Next state: walk the frame one bit period at a time, abandoning a start bit that samples high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!bus.rx_in) state_d = START;
      START: begin
        if (sample_vld && sample_now) state_d = IDLE;
        else if (last_edge)           state_d = DATA;
      end
      DATA:    if (last_edge && bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (last_edge) state_d = STOP;
      STOP:    if (last_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and frame-end outputs: counters, sampling, shifting, parity tracking and result pulses.
  always_comb begin
    edge_cnt_d     = 6'd0;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    prescale_d     = prescale_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    sample_d       = sample_q;
    par_err_d      = par_err_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    if (state_q == IDLE) begin
      if (!bus.rx_in) begin
        // This cycle is edge 0 of the start bit; freeze the frame configuration here.
        edge_cnt_d = 6'd1;
        prescale_d = bus.prescale;
        par_en_d   = bus.parity_EN;
        par_type_d = bus.parity_type;
        par_err_d  = 1'b0;
      end
    end else begin
      edge_cnt_d = last_edge ? 6'd0 : edge_cnt_q + 6'd1;
      if (sample_vld) sample_d = sample_now;
      unique case (state_q)
        START: begin
          if (sample_vld && sample_now) edge_cnt_d = 6'd0;
          else if (last_edge)           bit_cnt_d  = '0;
        end
        DATA: begin
          if (last_edge) begin
            shift_d[bit_cnt_q] = sample_q;
            bit_cnt_d          = bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (last_edge) par_err_d = (sample_q != ((^shift_q) ^ par_type_q));
        end
        STOP: begin
          if (last_edge) begin
            stop_error_d   = ~sample_q;
            parity_error_d = par_err_q;
            if (sample_q && !par_err_q) begin
              data_valid_d = 1'b1;
              p_data_d     = shift_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p_data       = p_data_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.parity_error = parity_error_q;
  assign bus.stop_error   = stop_error_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - self-checking bench for uart_rx_fsm: vector table, random frames, corner sequences
module tb_uart_rx_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fsm_if #(.DATA_WIDTH(8)) bus ();
  uart_rx_fsm #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } ev_t;
  ev_t ev_q[$];

  always @(negedge clk)
    if (bus.data_valid !== 1'b0 || bus.parity_error !== 1'b0 || bus.stop_error !== 1'b0)
      ev_q.push_back('{cyc, bus.data_valid, bus.parity_error, bus.stop_error, bus.p_data});

  typedef struct {
    string      name;
    logic [7:0] data;
    int         psc;
    bit         pen;
    bit         ptype;
    bit         pbit;
    bit         stop;
    bit         exp_dv;
    bit         exp_pe;
    bit         exp_se;
    logic [7:0] exp_pd;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pick_psc();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 8 : ((r == 1) ? 16 : 32);
  endfunction

  // Drives one frame starting now; spike_bit/spike_off invert a single cycle of one frame bit.
  task automatic send_frame(input logic [7:0] data, input int psc, input bit pen, input bit ptype,
                            input bit pbit, input bit stop, input int spike_bit, input int spike_off,
                            output int t0);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stop);
    bus.prescale    = 6'(psc);
    bus.parity_EN   = pen;
    bus.parity_type = ptype;
    t0 = cyc;
    for (int k = 0; k < bits.size(); k++) begin
      for (int e = 0; e < psc; e++) begin
        bus.rx_in = (k == spike_bit && e == spike_off) ? ~bits[k] : bits[k];
        if (k == 0 && e == 1) begin
          bus.prescale    = 6'(pick_psc());
          bus.parity_EN   = 1'($urandom_range(0, 1));
          bus.parity_type = 1'($urandom_range(0, 1));
        end
        cycles(1);
      end
    end
  endtask

  task automatic apply(input string name, input logic [7:0] data, input int psc, input bit pen,
                       input bit ptype, input bit pbit, input bit stop, input int sb, input int so,
                       input bit exp_dv, input bit exp_pe, input bit exp_se, input logic [7:0] exp_pd,
                       input int exp_lat);
    int t0;
    int n_exp;
    ev_q.delete();
    send_frame(data, psc, pen, ptype, pbit, stop, sb, so, t0);
    bus.rx_in = 1'b1;
    cycles(4);
    n_exp = (exp_dv || exp_pe || exp_se) ? 1 : 0;
    chk({name, "_nev"}, ev_q.size(), n_exp);
    if (ev_q.size() > 0) begin
      chk({name, "_cyc"}, ev_q[0].cyc, t0 + exp_lat);
      chk({name, "_dv"}, ev_q[0].dv, exp_dv);
      chk({name, "_pe"}, ev_q[0].pe, exp_pe);
      chk({name, "_se"}, ev_q[0].se, exp_se);
    end
    chk({name, "_pdata"}, bus.p_data, exp_pd);
    chk({name, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] model_pd;
    logic [7:0] spike_exp;
    int         t0;
    int         t1;

    vecs[0] = '{"a5_p8",     8'hA5, 8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 80};
    vecs[1] = '{"3c_even",   8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 176};
    vecs[2] = '{"3c_badpar", 8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 176};
    vecs[3] = '{"55_stop0",  8'h55, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 80};
    vecs[4] = '{"c3_odd",    8'hC3, 32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 352};
    vecs[5] = '{"0f_both",   8'h0F, 8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 88};

    bus.rx_in       = 1'b1;
    bus.prescale    = 6'd8;
    bus.parity_EN   = 1'b0;
    bus.parity_type = 1'b0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    chk("rst_pdata", bus.p_data, 0);
    chk("rst_dv", bus.data_valid, 0);
    chk("rst_pe", bus.parity_error, 0);
    chk("rst_se", bus.stop_error, 0);
    chk("rst_busy", bus.busy, 0);

    // Start-bit glitch: two low cycles, then high.
    ev_q.delete();
    bus.prescale = 6'd8;
    t0 = cyc;
    bus.rx_in = 1'b0;
    cycles(1);
    chk("glitch_busy_on", bus.busy, 1);
    cycles(1);
    bus.rx_in = 1'b1;
    cycles(3);
`ifdef UART_RX_MAJORITY_EN
    cycles(1);
`endif
    chk("glitch_busy_off", bus.busy, 0);
    cycles(20);
    chk("glitch_nev", ev_q.size(), 0);
    chk("glitch_pdata", bus.p_data, 0);

    // One-cycle spikes inside data bit 0 of 0xA5, at mid-1 and at mid.
    apply("spike_m1", 8'hA5, 8, 0, 0, 0, 1, 1, 3, 1, 0, 0, 8'hA5, 80);
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 8'hA5;
`else
    spike_exp = 8'hA4;
`endif
    apply("spike_mid", 8'hA5, 8, 0, 0, 0, 1, 1, 4, 1, 0, 0, spike_exp, 80);

    for (int i = 0; i < 6; i++)
      apply(vecs[i].name, vecs[i].data, vecs[i].psc, vecs[i].pen, vecs[i].ptype, vecs[i].pbit,
            vecs[i].stop, -1, 0, vecs[i].exp_dv, vecs[i].exp_pe, vecs[i].exp_se, vecs[i].exp_pd,
            vecs[i].exp_lat);

    // Random frames against a frame-level model: count ones for parity, check stop, track last good word.
    model_pd = 8'hC3;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      int         psc;
      bit         pen, ptype, good, pbit, stop, e_pe, e_se, e_dv;
      d     = 8'($urandom_range(0, 255));
      psc   = pick_psc();
      pen   = 1'($urandom_range(0, 1));
      ptype = 1'($urandom_range(0, 1));
      good  = 1'(($countones(d) % 2) ^ int'(ptype));
      pbit  = good ^ ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 4) != 0);
      e_pe  = pen && (pbit != good);
      e_se  = !stop;
      e_dv  = !e_pe && !e_se;
      if (e_dv) model_pd = d;
      apply($sformatf("rnd%0d", i), d, psc, pen, ptype, pbit, stop, -1, 0, e_dv, e_pe, e_se,
            model_pd, (8 + 2 + int'(pen)) * psc);
    end

    // Back-to-back frames with no idle gap.
    ev_q.delete();
    send_frame(8'h01, 32, 0, 0, 0, 1, -1, 0, t0);
    send_frame(8'hFE, 32, 0, 0, 0, 1, -1, 0, t1);
    bus.rx_in = 1'b1;
    cycles(4);
    chk("b2b_nev", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      chk("b2b_cyc0", ev_q[0].cyc, t0 + 320);
      chk("b2b_pd0", ev_q[0].pd, 8'h01);
      chk("b2b_dv0", ev_q[0].dv, 1);
      chk("b2b_gap", ev_q[1].cyc - ev_q[0].cyc, 320);
      chk("b2b_pd1", ev_q[1].pd, 8'hFE);
      chk("b2b_dv1", ev_q[1].dv, 1);
    end

    // Break: line low for 100 cycles at prescale 8 gives a stop error, then an immediate new frame reading 0xFE.
    ev_q.delete();
    bus.prescale  = 6'd8;
    bus.parity_EN = 1'b0;
    t0 = cyc;
    bus.rx_in = 1'b0;
    cycles(100);
    bus.rx_in = 1'b1;
    cycles(80);
    chk("brk_nev", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      chk("brk_cyc0", ev_q[0].cyc, t0 + 80);
      chk("brk_se0", ev_q[0].se, 1);
      chk("brk_dv0", ev_q[0].dv, 0);
      chk("brk_cyc1", ev_q[1].cyc, t0 + 160);
      chk("brk_dv1", ev_q[1].dv, 1);
      chk("brk_pd1", ev_q[1].pd, 8'hFE);
    end

    // Reset in the middle of the data bits of 0x77.
    ev_q.delete();
    bus.prescale  = 6'd8;
    bus.parity_EN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [8:0] fr;
      fr = {8'h77, 1'b0};
      bus.rx_in = fr[k];
      cycles(8);
    end
    rst = 1'b1;
    bus.rx_in = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pdata", bus.p_data, 0);
    cycles(100);
    chk("midrst_nev", ev_q.size(), 0);
    chk("midrst_pdata_hold", bus.p_data, 0);
    apply("after_rst_12", 8'h12, 8, 0, 0, 0, 1, -1, 0, 1, 0, 0, 8'h12, 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Receive-side counterpart of the UART transmitter: deserialises one UART frame (start, DATA_WIDTH data bits LSB first, optional parity, one stop bit) from the serial line.
- Line is oversampled by a runtime prescale (8/16/32 clocks per bit).
- Checks framing and parity, then presents the parallel word with a one-cycle valid pulse to the system side.
- Sits between the asynchronous rx pin (already 2-flop synchronised upstream) and the register or FIFO layer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx_in  input  1  synchronised serial line; idles high.
- prescale  input  6  clocks per bit. Legal values are 8, 16, 32; other values give undefined behaviour.
- parity_EN  input  1  1 = frame carries a parity bit.
- parity_type  input  1  0 = even, 1 = odd.
- p_data  output  DATA_WIDTH  last correctly received word.
- data_valid  output  1  one-cycle pulse when p_data is updated.
- parity_error  output  1  one-cycle pulse at end of a frame with bad parity.
- stop_error  output  1  one-cycle pulse at end of a frame with stop bit sampled 0.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset: on rst=1 at a clk edge:
  - state returns to IDLE; all counters are cleared.
  - p_data=0, data_valid=0, parity_error=0, stop_error=0, busy=0.
  - Reset applies at any point in a frame; a partial frame is discarded with no pulses.
- Counters:
  - edge_cnt counts 0..prescale-1 within each bit and wraps to 0 at bit end.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
  - mid = prescale/2.
- Configuration: prescale, parity_EN and parity_type are latched on start detection and held for the whole frame. Changes mid-frame are ignored.
- States:
  - IDLE: when rx_in=0, that cycle is edge 0 of the start bit. Latch config, set edge_cnt=1, go to START. Otherwise stay.
  - START: take the sample (see Optional Feature).
    - If the sampled value is 1, the start bit is a glitch: return to IDLE with no outputs.
    - Otherwise, at edge_cnt=prescale-1 go to DATA with bit_cnt=0.
  - DATA: at bit end, shift the sample into the shift register at bit position bit_cnt (LSB first).
    - When bit_cnt=DATA_WIDTH-1, go to PARITY if parity_EN is latched, else go to STOP.
  - PARITY: the sampled bit must equal the XOR of the data bits, inverted when parity_type=1. The mismatch flag is held until frame end. At bit end go to STOP.
  - STOP: at edge_cnt=prescale-1, evaluate the frame and go to IDLE.
- Frame-end outputs, registered, asserted the cycle after the STOP bit end:
  - No errors: p_data <= shift register, data_valid=1.
  - Parity mismatch: parity_error=1.
  - Stop sampled 0: stop_error=1.
  - Both errors can pulse in the same cycle.
  - Any error: data_valid=0 and p_data is unchanged.
- Latency: with start detection at cycle T0, the frame-end pulse occurs at T0 + (DATA_WIDTH+2+parity_EN)*prescale.
  - Example, 8 data bits, no parity, prescale=8: T0+80.
- Back-to-back frames: if rx_in=0 in the first IDLE cycle after STOP, start detection happens that cycle. No idle gap is required.
- Break condition (rx_in held low): produces stop_error, then a new start detection as soon as IDLE is re-entered.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Samples are taken at edge_cnt = mid-1, mid, mid+1.
  - The bit value is the 2-of-3 majority, resolved at edge_cnt=mid+1.
  - The START glitch check uses the majority value.
- Undefined:
  - A single sample is taken at edge_cnt=mid.
  - The glitch check is made at mid.
  - The majority logic and its extra sample registers are not synthesised.
- Latency is identical in both builds.

Test Plan:
- Prescale=8, no parity, send 0xA5 with stop=1 -> data_valid pulses at T0+80, p_data=0xA5, both error flags 0.
- Prescale=16, parity_EN=1, parity_type=0, send 0x3C with correct even parity bit 0 -> data_valid at T0+176, p_data=0x3C. Repeat with the parity bit flipped -> parity_error pulse, data_valid=0, p_data holds 0x3C.
- Prescale=8, send 0x55 with stop bit=0 -> stop_error pulse at T0+80; p_data keeps its previous value.
- Glitch test: rx_in low for 2 cycles then high, prescale=8 -> return to IDLE; busy drops by T0+5; no pulses. With UART_RX_MAJORITY_EN defined, a 1-cycle low spike at sample mid inside a data bit is rejected and the correct byte is received.
- Back-to-back frames 0x01 then 0xFE with no idle gap, prescale=32 -> two data_valid pulses 320 cycles apart, values correct.
- Assert rst mid-DATA of frame 0x77, then send 0x12 -> no pulse for 0x77; p_data=0 until 0x12 is received, then data_valid with p_data=0x12.
